// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer rectangle-fill engine.
// Contents: default geometry constants, fill FSM state type and the
// rectangle command payload used by fill producers.
package fb_pkg;

  localparam int unsigned H_RES_DEFAULT      = 160;
  localparam int unsigned V_RES_DEFAULT      = 120;
  localparam int unsigned FB_DEPTH           = H_RES_DEFAULT * V_RES_DEFAULT;
  localparam int unsigned X_WIDTH_DEFAULT    = 8;
  localparam int unsigned Y_WIDTH_DEFAULT    = 7;
  localparam int unsigned DATA_WIDTH_DEFAULT = 1;
  localparam int unsigned ADDR_WIDTH_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  typedef struct packed {
    logic                          clear;
    logic [X_WIDTH_DEFAULT-1:0]    x0;
    logic [X_WIDTH_DEFAULT-1:0]    x1;
    logic [Y_WIDTH_DEFAULT-1:0]    y0;
    logic [Y_WIDTH_DEFAULT-1:0]    y1;
    logic [DATA_WIDTH_DEFAULT-1:0] color;
  } rect_cmd_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Raster address generator for the rectangle-fill engine.
// Walks x from x_lo to x_hi on each step, then wraps to the next row by
// adding H_RES to a running row base (no multiplier inside the loop).
// Ports:
//   clock, reset      write-side clock, synchronous active-high reset
//   load              capture normalised bounds and start at (x_lo, y_lo)
//   step              advance to the next pixel in raster order
//   x_lo/x_hi/y_lo/y_hi  normalised inclusive bounds (sampled on load)
//   addr_c            address of the current pixel (combinational)
//   last_c            current pixel is the bottom-right corner
module fb_addr_gen #(
  parameter int unsigned H_RES      = 160,
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned X_WIDTH    = 8,
  parameter int unsigned Y_WIDTH    = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [X_WIDTH-1:0]    x_lo,
  input  logic [X_WIDTH-1:0]    x_hi,
  input  logic [Y_WIDTH-1:0]    y_lo,
  input  logic [Y_WIDTH-1:0]    y_hi,
  output logic [ADDR_WIDTH-1:0] addr_c,
  output logic                  last_c
);

  logic [X_WIDTH-1:0]    x_q, xl_q, xh_q;
  logic [Y_WIDTH-1:0]    y_q, yh_q;
  logic [ADDR_WIDTH-1:0] row_q;

  // Counter state; row base is a constant multiply only at load time.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q   <= '0;
      xl_q  <= '0;
      xh_q  <= '0;
      y_q   <= '0;
      yh_q  <= '0;
      row_q <= '0;
    end else if (load) begin
      x_q   <= x_lo;
      xl_q  <= x_lo;
      xh_q  <= x_hi;
      y_q   <= y_lo;
      yh_q  <= y_hi;
      row_q <= ADDR_WIDTH'(32'(y_lo) * H_RES);
    end else if (step) begin
      if (x_q == xh_q) begin
        x_q   <= xl_q;
        y_q   <= y_q + Y_WIDTH'(1);
        row_q <= row_q + ADDR_WIDTH'(H_RES);
      end else begin
        x_q <= x_q + X_WIDTH'(1);
      end
    end
  end

  assign addr_c = row_q + ADDR_WIDTH'(x_q);
  assign last_c = (x_q == xh_q) && (y_q == yh_q);

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle / clear-screen fill engine driving the framebuffer write port.
// Accepts one command per valid/ready handshake and emits one pixel write
// per cycle while wr_ready is high, holding the write stable when it is low.
// Build option: FB_RECT_FILL_CLIP_EN clamps out-of-range bounds to the
// screen edge; without it such commands are rejected with an err pulse.
// Ports:
//   clock, reset       write-side clock, synchronous active-high reset
//   cmd_valid/ready    command handshake (ready only while idle)
//   cmd_clear          fill the whole screen, coordinates ignored
//   cmd_x0/x1, y0/y1   inclusive bounds, either order
//   cmd_color          fill value
//   write_addr/data/we framebuffer write port
//   wr_ready           downstream accepts the current write
//   busy, done, err    status; done/err are one-cycle pulses
module fb_rect_fill
  import fb_pkg::*;
#(
  parameter int unsigned H_RES      = H_RES_DEFAULT,
  parameter int unsigned V_RES      = V_RES_DEFAULT,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned X_WIDTH    = X_WIDTH_DEFAULT,
  parameter int unsigned Y_WIDTH    = Y_WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_clear,
  input  logic [X_WIDTH-1:0]    cmd_x0,
  input  logic [X_WIDTH-1:0]    cmd_x1,
  input  logic [Y_WIDTH-1:0]    cmd_y0,
  input  logic [Y_WIDTH-1:0]    cmd_y1,
  input  logic [DATA_WIDTH-1:0] cmd_color,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  we,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [X_WIDTH-1:0] X_MAX = X_WIDTH'(H_RES - 1);
  localparam logic [Y_WIDTH-1:0] Y_MAX = Y_WIDTH'(V_RES - 1);

  fill_state_t state_q, state_d;

  logic                  c_clear;
  logic [X_WIDTH-1:0]    c_x0, c_x1;
  logic [Y_WIDTH-1:0]    c_y0, c_y1;
  logic [DATA_WIDTH-1:0] c_color;
  logic                  pend_q, pend_d;

  logic                  cmd_ready_d, busy_d, done_d, err_d, we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  accept, load, step, range_bad;
  logic [X_WIDTH-1:0]    nx_lo, nx_hi;
  logic [Y_WIDTH-1:0]    ny_lo, ny_hi;
  logic [ADDR_WIDTH-1:0] gen_addr_c;
  logic                  gen_last_c;

  // Normalise the latched command: order bounds, apply clear, range policy.
  always_comb begin
    nx_lo = (c_x0 > c_x1) ? c_x1 : c_x0;
    nx_hi = (c_x0 > c_x1) ? c_x0 : c_x1;
    ny_lo = (c_y0 > c_y1) ? c_y1 : c_y0;
    ny_hi = (c_y0 > c_y1) ? c_y0 : c_y1;
    if (c_clear) begin
      nx_lo = '0;
      nx_hi = X_MAX;
      ny_lo = '0;
      ny_hi = Y_MAX;
    end
`ifdef FB_RECT_FILL_CLIP_EN
    if (nx_lo > X_MAX) nx_lo = X_MAX;
    if (nx_hi > X_MAX) nx_hi = X_MAX;
    if (ny_lo > Y_MAX) ny_lo = Y_MAX;
    if (ny_hi > Y_MAX) ny_hi = Y_MAX;
    range_bad = 1'b0;
`else
    // Lower bounds never exceed upper bounds here, so checking hi suffices.
    range_bad = (nx_hi > X_MAX) || (ny_hi > Y_MAX);
`endif
  end

  // Next state and next registered outputs. The generator counters point at
  // the next pixel to issue; pend tracks whether any pixel is still unissued.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    err_d       = 1'b0;
    we_d        = we;
    addr_d      = write_addr;
    data_d      = data;
    pend_d      = pend_q;
    accept      = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        we_d        = 1'b0;
        if (cmd_valid && cmd_ready) begin
          accept      = 1'b1;
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      SETUP: begin
        if (range_bad) begin
          err_d       = 1'b1;
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          load    = 1'b1;
          pend_d  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (!we || wr_ready) begin
          if (pend_q) begin
            we_d   = 1'b1;
            addr_d = gen_addr_c;
            data_d = c_color;
            step   = 1'b1;
            if (gen_last_c) pend_d = 1'b0;
          end else begin
            we_d    = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        we_d        = 1'b0;
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        we_d        = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      we         <= 1'b0;
      write_addr <= '0;
      data       <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_ready  <= cmd_ready_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      we         <= we_d;
      write_addr <= addr_d;
      data       <= data_d;
      pend_q     <= pend_d;
    end
  end

  // Command latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      c_clear <= 1'b0;
      c_x0    <= '0;
      c_x1    <= '0;
      c_y0    <= '0;
      c_y1    <= '0;
      c_color <= '0;
    end else if (accept) begin
      c_clear <= cmd_clear;
      c_x0    <= cmd_x0;
      c_x1    <= cmd_x1;
      c_y0    <= cmd_y0;
      c_y1    <= cmd_y1;
      c_color <= cmd_color;
    end
  end

  fb_addr_gen #(
    .H_RES      (H_RES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .X_WIDTH    (X_WIDTH),
    .Y_WIDTH    (Y_WIDTH)
  ) u_addr_gen (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .x_lo   (nx_lo),
    .x_hi   (nx_hi),
    .y_lo   (ny_lo),
    .y_hi   (ny_hi),
    .addr_c (gen_addr_c),
    .last_c (gen_last_c)
  );

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill at the default 160x120x1 geometry.
module tb_fb_rect_fill;
  import fb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_clear;
  logic [7:0]  cmd_x0, cmd_x1;
  logic [6:0]  cmd_y0, cmd_y1;
  logic [0:0]  cmd_color;
  logic [14:0] write_addr;
  logic [0:0]  data;
  logic        we, wr_ready, busy, done, err;

  always #5 clock = ~clock;

  fb_rect_fill dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_clear  (cmd_clear),
    .cmd_x0     (cmd_x0),
    .cmd_x1     (cmd_x1),
    .cmd_y0     (cmd_y0),
    .cmd_y1     (cmd_y1),
    .cmd_color  (cmd_color),
    .write_addr (write_addr),
    .data       (data),
    .we         (we),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int total = 0;
  int bad   = 0;

  // Write monitor with a raster-order reference model.
  int   n_wr, first_addr, last_addr, mism, hold_bad, n_done, n_err, rb_bad;
  int   mon_x, mon_y, ex_lo, ex_hi;
  logic ex_color;
  logic prev_stall = 1'b0;
  logic [14:0] prev_addr;
  logic [0:0]  prev_data;

  always @(negedge clock) begin
    if (!reset) begin
      if (prev_stall && (we !== 1'b1 || write_addr !== prev_addr || data !== prev_data))
        hold_bad++;
      if (we && wr_ready) begin
        if (n_wr == 0) first_addr = int'(write_addr);
        last_addr = int'(write_addr);
        n_wr++;
        if (int'(write_addr) != mon_y * 160 + mon_x || data !== ex_color) mism++;
        if (mon_x == ex_hi) begin
          mon_x = ex_lo;
          mon_y++;
        end else begin
          mon_x++;
        end
      end
      if (done) n_done++;
      if (err) n_err++;
      if (busy && cmd_ready) rb_bad++;
      prev_stall = we && !wr_ready;
      prev_addr  = write_addr;
      prev_data  = data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic set_exp(input int xl, input int xh, input int yl, input logic c);
    ex_lo = xl; ex_hi = xh; mon_x = xl; mon_y = yl; ex_color = c;
    n_wr = 0; first_addr = -1; last_addr = -1; mism = 0; hold_bad = 0;
    n_done = 0; n_err = 0; rb_bad = 0;
  endtask

  // Present a command and return just after the accepting edge.
  task automatic start_cmd(input rect_cmd_t c, output bit ok);
    @(posedge clock); #1;
    cmd_clear = c.clear; cmd_x0 = c.x0; cmd_x1 = c.x1;
    cmd_y0 = c.y0; cmd_y1 = c.y1; cmd_color = c.color;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30000 && !ok; i++) begin
      @(negedge clock);
      if (cmd_ready) ok = 1'b1;
      @(posedge clock); #1;
    end
    cmd_valid = 1'b0;
  endtask

  // Run until done or err; cyc counts the accepting edge as 1.
  task automatic run(input int budget, input bit toggle,
                     output int cyc, output int lat, output bit to);
    cyc = 1; lat = -1; to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (we && lat < 0) lat = cyc - 1;
      if (done || err) begin
        to = 1'b0;
        break;
      end
      @(posedge clock); #1;
      cyc++;
      if (toggle) wr_ready = ~wr_ready;
    end
    wr_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

  function automatic rect_cmd_t mk(input logic cl, input int x0, input int x1,
                                   input int y0, input int y1, input logic c);
    rect_cmd_t r;
    r.clear = cl; r.x0 = 8'(x0); r.x1 = 8'(x1);
    r.y0 = 7'(y0); r.y1 = 7'(y1); r.color = c;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got %b want 0", we); end
    total++; if (write_addr !== 15'd0) begin bad++; $display("FAIL reset_addr got %0d want 0", write_addr); end
    total++; if (data !== 1'b0) begin bad++; $display("FAIL reset_data got %b want 0", data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if ({done, err} !== 2'b00) begin bad++; $display("FAIL reset_done_err got %b want 00", {done, err}); end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_rect();
    bit ok, to; int cyc, lat;
    set_exp(40, 119, 30, 1'b0);
    start_cmd(mk(1'b0, 40, 119, 30, 89, 1'b0), ok);
    run(6000, 1'b0, cyc, lat, to);
    total++; if (!ok || to) begin bad++; $display("FAIL rect_timeout accepted=%0d timeout=%0d want 1/0", ok, to); end
    total++; if (n_wr != 4800) begin bad++; $display("FAIL rect_count got %0d want 4800", n_wr); end
    total++; if (first_addr != 4840) begin bad++; $display("FAIL rect_first got %0d want 4840", first_addr); end
    total++; if (last_addr != 14359) begin bad++; $display("FAIL rect_last got %0d want 14359", last_addr); end
    total++; if (mism != 0) begin bad++; $display("FAIL rect_order got %0d bad writes want 0", mism); end
    total++; if (n_done != 1) begin bad++; $display("FAIL rect_done got %0d pulses want 1", n_done); end
    total++; if (cyc != 4803) begin bad++; $display("FAIL rect_cycles got %0d want 4803", cyc); end
    total++; if (lat != 2) begin bad++; $display("FAIL rect_latency got %0d want 2", lat); end
  endtask

  task automatic test_clear();
    bit ok, to; int cyc, lat;
    set_exp(0, 159, 0, 1'b1);
    start_cmd(mk(1'b1, 7, 3, 9, 2, 1'b1), ok);
    run(20000, 1'b0, cyc, lat, to);
    total++; if (n_wr != 19200) begin bad++; $display("FAIL clear_count got %0d want 19200", n_wr); end
    total++; if (first_addr != 0 || last_addr != 19199) begin bad++; $display("FAIL clear_range got %0d..%0d want 0..19199", first_addr, last_addr); end
    total++; if (mism != 0) begin bad++; $display("FAIL clear_contig got %0d bad writes want 0", mism); end
    total++; if (n_done != 1 || to) begin bad++; $display("FAIL clear_done got %0d timeout=%0d want 1/0", n_done, to); end
  endtask

  task automatic test_swap();
    bit ok, to; int cyc, lat;
    set_exp(5, 10, 2, 1'b1);
    start_cmd(mk(1'b0, 10, 5, 3, 2, 1'b1), ok);
    run(200, 1'b0, cyc, lat, to);
    total++; if (n_wr != 12) begin bad++; $display("FAIL swap_count got %0d want 12", n_wr); end
    total++; if (first_addr != 325 || last_addr != 490) begin bad++; $display("FAIL swap_range got %0d..%0d want 325..490", first_addr, last_addr); end
    total++; if (mism != 0 || n_done != 1) begin bad++; $display("FAIL swap_order got bad=%0d done=%0d want 0/1", mism, n_done); end
  endtask

  task automatic test_single();
    bit ok, to; int cyc, lat;
    set_exp(159, 159, 119, 1'b1);
    start_cmd(mk(1'b0, 159, 159, 119, 119, 1'b1), ok);
    run(200, 1'b0, cyc, lat, to);
    total++; if (n_wr != 1 || first_addr != 19199) begin bad++; $display("FAIL single_write got n=%0d addr=%0d want 1/19199", n_wr, first_addr); end
    total++; if (n_done != 1 || cyc != 4) begin bad++; $display("FAIL single_done got done=%0d cyc=%0d want 1/4", n_done, cyc); end
  endtask

  task automatic test_stall();
    bit ok, to; int cyc, lat;
    set_exp(20, 23, 10, 1'b1);
    start_cmd(mk(1'b0, 20, 23, 10, 13, 1'b1), ok);
    run(300, 1'b1, cyc, lat, to);
    total++; if (n_wr != 16) begin bad++; $display("FAIL stall_count got %0d want 16", n_wr); end
    total++; if (first_addr != 1620 || last_addr != 2103) begin bad++; $display("FAIL stall_range got %0d..%0d want 1620..2103", first_addr, last_addr); end
    total++; if (mism != 0) begin bad++; $display("FAIL stall_order got %0d bad writes want 0", mism); end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL stall_hold got %0d unstable cycles want 0", hold_bad); end
    total++; if (n_done != 1 || to) begin bad++; $display("FAIL stall_done got %0d timeout=%0d want 1/0", n_done, to); end
  endtask

  task automatic test_range();
    bit ok, to; int cyc, lat;
    set_exp(0, 159, 5, 1'b1);
    start_cmd(mk(1'b0, 0, 200, 5, 5, 1'b1), ok);
    run(400, 1'b0, cyc, lat, to);
`ifdef FB_RECT_FILL_CLIP_EN
    total++; if (n_wr != 160 || first_addr != 800 || last_addr != 959) begin bad++; $display("FAIL clip_writes got n=%0d %0d..%0d want 160 800..959", n_wr, first_addr, last_addr); end
    total++; if (n_err != 0 || n_done != 1) begin bad++; $display("FAIL clip_status got err=%0d done=%0d want 0/1", n_err, n_done); end
`else
    total++; if (n_err != 1 || cyc != 2) begin bad++; $display("FAIL reject_err got pulses=%0d cyc=%0d want 1/2", n_err, cyc); end
    total++; if (n_wr != 0 || n_done != 0) begin bad++; $display("FAIL reject_writes got n=%0d done=%0d want 0/0", n_wr, n_done); end
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reject_ready got ready=%b busy=%b want 1/0", cmd_ready, busy); end
`endif
  endtask

  task automatic test_reset_mid_fill();
    bit ok, to; int cyc, lat;
    set_exp(0, 159, 0, 1'b1);
    start_cmd(mk(1'b1, 0, 0, 0, 0, 1'b1), ok);
    repeat (101) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    total++; if (we !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL midreset_outputs got we=%b ready=%b busy=%b want 0/1/0", we, cmd_ready, busy); end
    repeat (5) @(negedge clock);
    total++; if (n_done != 0 || we !== 1'b0) begin bad++; $display("FAIL midreset_quiet got done=%0d we=%b want 0/0", n_done, we); end
    set_exp(20, 23, 10, 1'b0);
    start_cmd(mk(1'b0, 23, 20, 13, 10, 1'b0), ok);
    run(200, 1'b0, cyc, lat, to);
    total++; if (n_wr != 16 || mism != 0 || n_done != 1) begin bad++; $display("FAIL midreset_next got n=%0d bad=%0d done=%0d want 16/0/1", n_wr, mism, n_done); end
  endtask

  task automatic test_back_to_back();
    bit ok_a, ok_b, to; int cyc, lat;
    set_exp(0, 1, 0, 1'b1);
    start_cmd(mk(1'b0, 0, 1, 0, 0, 1'b1), ok_a);
    start_cmd(mk(1'b0, 0, 1, 1, 1, 1'b1), ok_b);
    run(200, 1'b0, cyc, lat, to);
    total++; if (!ok_a || !ok_b || n_wr != 4 || mism != 0) begin bad++; $display("FAIL b2b_writes got acc=%0d%0d n=%0d bad=%0d want 11/4/0", ok_a, ok_b, n_wr, mism); end
    total++; if (n_done != 2 || rb_bad != 0) begin bad++; $display("FAIL b2b_status got done=%0d ready_while_busy=%0d want 2/0", n_done, rb_bad); end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_clear = 1'b0; wr_ready = 1'b1;
    cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_color = '0;
    set_exp(0, 0, 0, 1'b0);
    test_reset();
    test_rect();
    test_clear();
    test_swap();
    test_single();
    test_stall();
    test_range();
    test_reset_mid_fill();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
